// File: rtl/mem_io_bridge_pkg.sv
// mem_io_bridge_pkg: shared constants and types for the CPU memory / I/O bridge.
// Holds the I/O region decode, the port offsets within it and the read-return
// select encoding used by the top level.
package mem_io_bridge_pkg;

  // Base of the I/O region; only bits 17:16 take part in the decode.
  localparam logic [17:0] IO_BASE      = 18'h30000;

  // Offsets within the I/O region (low three address bits).
  localparam logic [2:0]  IO_PORT_DATA = 3'd0;
  localparam logic [2:0]  IO_PORT_CLK  = 3'd4;

  // Width of the registered read-select encoding.
  localparam int          RD_SEL_W     = 2;

  // Which I/O source produced the byte returned on the next cycle.
  typedef enum logic [RD_SEL_W-1:0] {
    SEL_NONE = 2'd0,
    SEL_DATA = 2'd1,
    SEL_CLK  = 2'd2
  } rd_sel_e;

  // Program-stop sequencing.
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_STOPPED = 2'd2
  } stop_state_e;

  // True when an address falls in the I/O region.
  function automatic logic is_io_addr(input logic [17:0] addr);
    return addr[17:16] == IO_BASE[17:16];
  endfunction

endpackage

// File: rtl/mem_io_bridge_fifo.sv
// byte_fifo: byte-wide synchronous FIFO of 2**DEPTH_BIT entries.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
// A pop and a push in the same cycle are both honoured, even when full.
// afull is a registered flag that is set when the occupancy is at least depth-1.
module byte_fifo #(
  parameter int DEPTH_BIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [7:0]         din,
  input  logic               pop,
  output logic [7:0]         dout,
  output logic               full,
  output logic               empty,
  output logic               afull,
  output logic [DEPTH_BIT:0] count
);

  localparam int               DEPTH     = 2 ** DEPTH_BIT;
  localparam logic [DEPTH_BIT:0] AFULL_LVL = (DEPTH_BIT + 1)'(DEPTH - 1);

  logic [7:0]         mem [DEPTH];
  logic [DEPTH_BIT:0] wr_ptr, rd_ptr, wr_next, rd_next;
  logic               do_push, do_pop;

  // A pop on a full FIFO frees the slot that the same-cycle push refills.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign wr_next = wr_ptr + (DEPTH_BIT + 1)'(do_push);
  assign rd_next = rd_ptr + (DEPTH_BIT + 1)'(do_pop);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_BIT] != rd_ptr[DEPTH_BIT]) &&
                 (wr_ptr[DEPTH_BIT-1:0] == rd_ptr[DEPTH_BIT-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign dout  = empty ? 8'h00 : mem[rd_ptr[DEPTH_BIT-1:0]];

  // Storage write.
  // NOTE: the data array has no reset; the pointers alone define what is valid,
  // and leaving it out lets synthesis map the array onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[DEPTH_BIT-1:0]] <= din;
  end

  // Pointer and almost-full registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      afull  <= 1'b0;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      afull  <= (wr_next - rd_next) >= AFULL_LVL;
    end
  end

endmodule

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: routes the CPU byte bus to RAM or to the I/O region
// (address bits 17:16 == 2'b11) holding the UART TX/RX FIFOs, a cycle
// counter with snapshot, and program-stop. Read data returns one cycle later.
// Optional build macro IO_STOP_FLUSH_EN: a stop write first drains the TX
// FIFO and only then raises program_done.
module mem_io_bridge
  import mem_io_bridge_pkg::*;
#(
  parameter int TX_DEPTH_BIT = 4,
  parameter int RX_DEPTH_BIT = 4,
  parameter int RAM_ADDR_BIT = 17
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    rdy_in,
  input  logic [31:0]             cpu_a,
  input  logic [7:0]              cpu_dout,
  input  logic                    cpu_wr,
  output logic [7:0]              cpu_din,
  output logic                    cpu_io_full,
  output logic [RAM_ADDR_BIT-1:0] ram_a,
  output logic [7:0]              ram_dout,
  output logic                    ram_we,
  input  logic [7:0]              ram_din,
  output logic [7:0]              uart_tx_data,
  output logic                    uart_tx_valid,
  input  logic                    uart_tx_ready,
  input  logic [7:0]              uart_rx_data,
  input  logic                    uart_rx_valid,
  output logic                    program_done
);

  logic        is_io, io_wr, io_rd;
  logic [2:0]  io_lo;
  logic        data_wr, stop_wr, data_rd, clk_rd;
  logic        push_open, tx_push, tx_pop, tx_full, tx_empty;
  logic        rx_push, rx_pop, rx_full, rx_empty, rx_afull;
  logic [7:0]  rx_head;
  logic [TX_DEPTH_BIT:0] tx_count;
  logic [RX_DEPTH_BIT:0] rx_count;
  logic [31:0] cycle_cnt, snapshot;
  logic [7:0]  overflow_cnt, io_byte_d, io_byte_q;
  logic        src_q;
  rd_sel_e     sel_d, sel_q;
  stop_state_e state_q, state_d;
  logic        unused_ok;

  // Address decode; everything that changes state is qualified by rdy_in.
  assign is_io   = is_io_addr(cpu_a[17:0]);
  assign io_lo   = cpu_a[2:0];
  assign io_wr   = rdy_in & is_io & cpu_wr;
  assign io_rd   = rdy_in & is_io & ~cpu_wr;
  assign data_wr = io_wr & (io_lo == IO_PORT_DATA);
  assign stop_wr = io_wr & (io_lo == IO_PORT_CLK);
  assign data_rd = io_rd & (io_lo == IO_PORT_DATA);
  assign clk_rd  = io_rd & (io_lo == IO_PORT_CLK);

  // RAM path is a straight pass-through.
  assign ram_a    = cpu_a[RAM_ADDR_BIT-1:0];
  assign ram_dout = cpu_dout;
  assign ram_we   = cpu_wr & ~is_io & rdy_in;

`ifdef IO_STOP_FLUSH_EN
  assign push_open = (state_q == ST_RUN);
`else
  assign push_open = 1'b1;
`endif

  assign tx_push = data_wr & (cpu_dout != 8'h00) & push_open;
  assign tx_pop  = rdy_in & uart_tx_valid & uart_tx_ready;
  assign rx_push = rdy_in & uart_rx_valid;
  assign rx_pop  = data_rd;

  assign uart_tx_valid = ~tx_empty;

  byte_fifo #(.DEPTH_BIT(TX_DEPTH_BIT)) u_tx (
    .clk(clk_in), .rst_n(rst_n_in), .push(tx_push), .din(cpu_dout), .pop(tx_pop),
    .dout(uart_tx_data), .full(tx_full), .empty(tx_empty), .afull(cpu_io_full),
    .count(tx_count)
  );

  byte_fifo #(.DEPTH_BIT(RX_DEPTH_BIT)) u_rx (
    .clk(clk_in), .rst_n(rst_n_in), .push(rx_push), .din(uart_rx_data), .pop(rx_pop),
    .dout(rx_head), .full(rx_full), .empty(rx_empty), .afull(rx_afull),
    .count(rx_count)
  );

  // I/O read byte and its select, decoded in the request cycle.
  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    io_byte_d = 8'h00;
    sel_d     = SEL_NONE;
    if (io_rd) begin
      case (io_lo)
        IO_PORT_DATA: begin io_byte_d = rx_head;          sel_d = SEL_DATA; end
        IO_PORT_CLK:  begin io_byte_d = cycle_cnt[7:0];   sel_d = SEL_CLK;  end
        3'd5:         begin io_byte_d = snapshot[15:8];   sel_d = SEL_CLK;  end
        3'd6:         begin io_byte_d = snapshot[23:16];  sel_d = SEL_CLK;  end
        3'd7:         begin io_byte_d = snapshot[31:24];  sel_d = SEL_CLK;  end
        default:      begin io_byte_d = 8'h00;            sel_d = SEL_NONE; end
      endcase
    end
  end

  // Read-return registers: source, select and the captured I/O byte.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      src_q     <= 1'b0;
      sel_q     <= SEL_NONE;
      io_byte_q <= 8'h00;
    end else if (rdy_in) begin
      src_q     <= ~cpu_wr & ~is_io;
      sel_q     <= sel_d;
      io_byte_q <= io_byte_d;
    end
  end

  assign cpu_din = src_q ? ram_din : ((sel_q == SEL_NONE) ? 8'h00 : io_byte_q);

  // Free-running cycle counter, snapshot and TX overflow counter.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cycle_cnt    <= 32'd0;
      snapshot     <= 32'd0;
      overflow_cnt <= 8'd0;
    end else begin
      if (rdy_in) cycle_cnt <= cycle_cnt + 32'd1;
      if (clk_rd) snapshot <= cycle_cnt;
      if (tx_push && tx_full && !tx_pop && overflow_cnt != 8'hFF)
        overflow_cnt <= overflow_cnt + 8'd1;
    end
  end

  // Stop state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= ST_RUN;
    else           state_q <= state_d;
  end

  // Stop next-state: drain the TX FIFO first when the flush feature is built in.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
`ifdef IO_STOP_FLUSH_EN
        if (stop_wr) state_d = ST_DRAIN;
`else
        if (stop_wr) state_d = ST_STOPPED;
`endif
      end
      ST_DRAIN:   if (rdy_in && tx_empty) state_d = ST_STOPPED;
      ST_STOPPED: state_d = ST_STOPPED;
      default:    state_d = ST_RUN;
    endcase
  end

  assign program_done = (state_q == ST_STOPPED);

  assign unused_ok = &{1'b0, cpu_a[31:18], tx_count, rx_count, rx_full, rx_afull};

endmodule

// File: tb/tb_mem_io_bridge.sv
// tb_mem_io_bridge: directed bench for mem_io_bridge. A table of bus vectors
// covers RAM and I/O decode; hand-written sequences cover the counter snapshot,
// rdy_in freeze, TX ordering/full behaviour, RX ordering and program stop.
module tb_mem_io_bridge;

  logic        clk_in = 1'b0, rst_n_in = 1'b0, rdy_in = 1'b0;
  logic [31:0] cpu_a = '0;
  logic [7:0]  cpu_dout = '0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_din;
  logic        cpu_io_full;
  logic [16:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_we;
  logic [7:0]  ram_din = 8'h00;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready = 1'b0;
  logic [7:0]  uart_rx_data = 8'h00;
  logic        uart_rx_valid = 1'b0;
  logic        program_done;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] ram [0:131071];
  logic [7:0] tx_q [$];
  logic       io_we_seen = 1'b0;

  mem_io_bridge dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
    .cpu_io_full(cpu_io_full), .ram_a(ram_a), .ram_dout(ram_dout), .ram_we(ram_we),
    .ram_din(ram_din), .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid),
    .uart_tx_ready(uart_tx_ready), .uart_rx_data(uart_rx_data),
    .uart_rx_valid(uart_rx_valid), .program_done(program_done)
  );

  always #5 clk_in = ~clk_in;

  // Synchronous RAM model with one cycle of read latency.
  always @(posedge clk_in) begin
    if (ram_we) ram[ram_a] <= ram_dout;
    ram_din <= ram[ram_a];
  end

  // Record every byte the transmitter accepts, and any RAM write into I/O space.
  always @(negedge clk_in) begin
    if (rst_n_in && rdy_in && uart_tx_valid && uart_tx_ready) tx_q.push_back(uart_tx_data);
    if (ram_we && cpu_a[17:16] == 2'b11) io_we_seen <= 1'b1;
  end

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [7:0]  d;
    logic        chk;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic park();
    cpu_a = 32'h0; cpu_wr = 1'b0; cpu_dout = 8'h00;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [7:0] d);
    cpu_a = a; cpu_wr = 1'b1; cpu_dout = d;
    tick();
    park();
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [7:0] d);
    cpu_a = a; cpu_wr = 1'b0;
    tick();
    d = cpu_din;
    park();
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    uart_rx_data = b; uart_rx_valid = 1'b1;
    tick();
    uart_rx_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] exp_tx [17];

    vecs[0]  = '{1'b1, 32'h00100, 8'hA5, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 32'h00100, 8'h00, 1'b1, 8'hA5};
    vecs[2]  = '{1'b1, 32'h20005, 8'h77, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 32'h00005, 8'h00, 1'b1, 8'h77};
    vecs[4]  = '{1'b1, 32'h1FFFF, 8'h3C, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 32'h1FFFF, 8'h00, 1'b1, 8'h3C};
    vecs[6]  = '{1'b0, 32'h30000, 8'h00, 1'b1, 8'h31};
    vecs[7]  = '{1'b0, 32'h30000, 8'h00, 1'b1, 8'h32};
    vecs[8]  = '{1'b0, 32'h30000, 8'h00, 1'b1, 8'h00};
    vecs[9]  = '{1'b1, 32'h30001, 8'h55, 1'b0, 8'h00};
    vecs[10] = '{1'b0, 32'h30001, 8'h00, 1'b1, 8'h00};
    vecs[11] = '{1'b0, 32'h30003, 8'h00, 1'b1, 8'h00};
    vecs[12] = '{1'b0, 32'h00100, 8'h00, 1'b1, 8'hA5};

    // Reset state.
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_program_done", program_done, 0);
    check("rst_tx_valid", uart_tx_valid, 0);
    check("rst_io_full", cpu_io_full, 0);
    check("rst_cpu_din", cpu_din, 0);
    check("rst_tx_data", uart_tx_data, 0);
    check("rst_ram_we", ram_we, 0);

    // Counter snapshot: 511 enabled cycles after reset the counter is 0x1FF.
    rst_n_in = 1'b1; rdy_in = 1'b1;
    repeat (511) @(posedge clk_in);
    #1;
    cpu_a = 32'h30004; tick(); check("snap_b0", cpu_din, 8'hFF);
    cpu_a = 32'h30005; tick(); check("snap_b1", cpu_din, 8'h01);
    cpu_a = 32'h30006; tick(); check("snap_b2", cpu_din, 8'h00);
    cpu_a = 32'h30007; tick(); check("snap_b3", cpu_din, 8'h00);
    park();

    // rdy_in low for 10 cycles: counter (now 0x203) frozen, no writes take effect.
    rdy_in = 1'b0;
    cpu_a = 32'h00200; cpu_wr = 1'b1; cpu_dout = 8'h66;
    #1;
    check("ram_we_rdy_low", ram_we, 0);
    repeat (5) tick();
    cpu_a = 32'h30000; cpu_dout = 8'h5A;
    repeat (5) tick();
    check("tx_push_rdy_low", uart_tx_valid, 0);
    park();
    rdy_in = 1'b1;
    bus_rd(32'h30004, d);
    check("cnt_frozen", d, 8'h03);

    // RX bytes, then the decode table.
    rx_pulse(8'h31);
    rx_pulse(8'h32);
    for (int i = 0; i < 13; i++) begin
      cpu_a = vecs[i].a; cpu_wr = vecs[i].wr; cpu_dout = vecs[i].d;
      tick();
      if (vecs[i].chk) check($sformatf("vec%0d", i), cpu_din, vecs[i].exp);
    end
    park();

    // RX pop and push in the same cycle.
    rx_pulse(8'h41);
    cpu_a = 32'h30000; cpu_wr = 1'b0; uart_rx_data = 8'h42; uart_rx_valid = 1'b1;
    tick();
    check("rx_same_pop", cpu_din, 8'h41);
    uart_rx_valid = 1'b0; park();
    bus_rd(32'h30000, d); check("rx_same_push", d, 8'h42);
    bus_rd(32'h30000, d); check("rx_after_empty", d, 8'h00);

    // TX normal: zero bytes are never queued.
    uart_tx_ready = 1'b1;
    tx_q.delete();
    bus_wr(32'h30000, 8'h48);
    bus_wr(32'h30000, 8'h00);
    bus_wr(32'h30000, 8'h69);
    repeat (4) tick();
    check("tx_norm_count", tx_q.size(), 2);
    check("tx_norm_0", tx_q[0], 8'h48);
    check("tx_norm_1", tx_q[1], 8'h69);
    check("tx_norm_idle", uart_tx_valid, 0);

    // TX full, overflow and same-cycle push/pop.
    uart_tx_ready = 1'b0;
    tx_q.delete();
    for (int i = 1; i <= 15; i++) begin
      bus_wr(32'h30000, 8'(i));
      if (i == 14) check("io_full_at14", cpu_io_full, 0);
    end
    check("io_full_at15", cpu_io_full, 1);
    bus_wr(32'h30000, 8'h10);
    check("tx_count_16", dut.tx_count, 16);
    bus_wr(32'h30000, 8'h11);
    check("overflow_1", dut.overflow_cnt, 1);
    check("tx_count_drop", dut.tx_count, 16);
    cpu_a = 32'h30000; cpu_wr = 1'b1; cpu_dout = 8'h12; uart_tx_ready = 1'b1;
    tick();
    uart_tx_ready = 1'b0; park();
    check("tx_count_pushpop", dut.tx_count, 16);
    check("overflow_pushpop", dut.overflow_cnt, 1);
    check("io_full_pushpop", cpu_io_full, 1);
    uart_tx_ready = 1'b1;
    for (int k = 0; k < 40 && uart_tx_valid; k++) tick();
    check("tx_full_drained", uart_tx_valid, 0);
    check("io_full_drained", cpu_io_full, 0);
    for (int i = 0; i < 16; i++) exp_tx[i] = 8'(i + 1);
    exp_tx[16] = 8'h12;
    check("tx_full_count", tx_q.size(), 17);
    for (int i = 0; i < 17; i++) check($sformatf("tx_full_%0d", i), tx_q[i], exp_tx[i]);

    // Program stop with three bytes pending in TX.
    uart_tx_ready = 1'b0;
    tx_q.delete();
    rx_pulse(8'h44);
    bus_wr(32'h30000, 8'hA1);
    bus_wr(32'h30000, 8'hA2);
    bus_wr(32'h30000, 8'hA3);
    check("done_before_stop", program_done, 0);
    bus_wr(32'h30004, 8'h00);
`ifdef IO_STOP_FLUSH_EN
    check("done_draining", program_done, 0);
    bus_wr(32'h30000, 8'h99);
    uart_tx_ready = 1'b1;
    for (int k = 0; k < 20 && uart_tx_valid; k++) tick();
    check("drain_empty", uart_tx_valid, 0);
    check("done_at_empty", program_done, 0);
    tick();
    check("done_after_empty", program_done, 1);
    check("drain_count", tx_q.size(), 3);
    check("drain_0", tx_q[0], 8'hA1);
    check("drain_1", tx_q[1], 8'hA2);
    check("drain_2", tx_q[2], 8'hA3);
`else
    check("done_next_cycle", program_done, 1);
    check("tx_still_pending", uart_tx_valid, 1);
`endif

    // Asynchronous reset mid-cycle clears done and discards FIFO contents.
    #2;
    rst_n_in = 1'b0;
    #1;
    check("async_rst_done", program_done, 0);
    check("async_rst_tx", uart_tx_valid, 0);
    check("async_rst_full", cpu_io_full, 0);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    bus_rd(32'h30000, d);
    check("rx_discarded", d, 8'h00);

    check("no_ram_we_in_io", io_we_seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
